// File: rtl/patterner_pkg.sv
// Shared constants and helpers for the key-wire-group patterner.
package patterner_pkg;

  // trig_mode encodings
  localparam logic [1:0] TM_BOTH      = 2'd0;
  localparam logic [1:0] TM_KILL_COLL = 2'd1;
  localparam logic [1:0] TM_KILL_ACC  = 2'd2;
  localparam logic [1:0] TM_ACC_VETO  = 2'd3;

  // Upper bound on layer count accepted by popcount_layers.
  localparam int unsigned MAX_NLY = 32;

  // Count the layers that carry at least one masked hit.
  function automatic int unsigned popcount_layers(input logic [MAX_NLY-1:0] hits);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < MAX_NLY; i++) begin
      n = n + {31'd0, hits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/patterner_chan.sv
// One pattern-type channel: envelope masking, layer count, saturating BX
// counter and retrigger dead-time. The supplied veto is folded into rv_o so
// that a vetoed trigger does not arm the dead-time.
module patterner_chan
  import patterner_pkg::*;
#(
  parameter int unsigned NLY  = 6,
  parameter int unsigned LYW  = 3,
  parameter int unsigned BXW  = 3,
  parameter int unsigned CNTW = 3,
  parameter int unsigned DTW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NLY*LYW-1:0]  ly_i,
  input  logic [NLY*LYW-1:0]  mask_i,
  input  logic [BXW-1:0]      drifttime_i,
  input  logic [CNTW-1:0]     pretrig_i,
  input  logic [CNTW-1:0]     trig_i,
  input  logic [DTW-1:0]      dead_i,
  input  logic                kill_i,
  input  logic                veto_i,
  output logic                rv_o,
  output logic [CNTW-1:0]     sum_o
);

  localparam logic [BXW-1:0] BX_MAX = '1;

  logic [NLY-1:0]  hits_s;
  logic [CNTW-1:0] sum_s;
  logic            rv_s;
  logic [BXW-1:0]  bx_q, bx_d;
  logic [DTW-1:0]  dt_q, dt_d;

  // A layer counts as hit when any of its wires survives the envelope mask.
  always_comb begin
    hits_s = '0;
    for (int i = 0; i < NLY; i++) begin
      hits_s[i] = |(ly_i[i*LYW +: LYW] & mask_i[i*LYW +: LYW]);
    end
  end

  assign sum_s = CNTW'(popcount_layers(MAX_NLY'(hits_s)));

  // Trigger decision uses the BX count registered before this cycle's sum.
  // The pretrigger threshold also gates the trigger, so trig < pretrig
  // behaves as if trig equalled pretrig.
  always_comb begin
    rv_s = 1'b0;
    if (!kill_i && !veto_i && (dt_q == '0) && (bx_q == drifttime_i) &&
        (sum_s >= trig_i) && (sum_s >= pretrig_i)) begin
      rv_s = 1'b1;
    end else begin
      rv_s = 1'b0;
    end
  end

  // BX counter restarts whenever the pattern drops below pretrigger, saturates otherwise.
  always_comb begin
    bx_d = bx_q;
    if (kill_i || (sum_s < pretrig_i)) begin
      bx_d = '0;
    end else if (bx_q != BX_MAX) begin
      bx_d = bx_q + 1'b1;
    end else begin
      bx_d = bx_q;
    end
  end

  // Dead-time reloads on a trigger and counts down to zero otherwise.
  always_comb begin
    dt_d = dt_q;
    if (rv_s) begin
      dt_d = dead_i;
    end else if (dt_q != '0) begin
      dt_d = dt_q - 1'b1;
    end else begin
      dt_d = dt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q <= '0;
      dt_q <= '0;
    end else begin
      bx_q <= bx_d;
      dt_q <= dt_d;
    end
  end

  assign rv_o  = rv_s;
  assign sum_o = sum_s;

endmodule

// File: rtl/patterner_gen.sv
// Collision/accelerator patterner for one key wire group: two channels,
// trig_mode kill/veto logic and registered valid/quality outputs.
module patterner_gen
  import patterner_pkg::*;
#(
  parameter int unsigned NLY  = 6,
  parameter int unsigned LYW  = 3,
  parameter int unsigned BXW  = 3,
  parameter int unsigned CNTW = 3,
  parameter int unsigned QOFS = 3,
  parameter int unsigned DTW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NLY*LYW-1:0] ly,
  input  logic [NLY*LYW-1:0] coll_mask,
  input  logic [NLY*LYW-1:0] acc_mask,
  input  logic [BXW-1:0]     drifttime,
  input  logic [CNTW-1:0]    pretrig,
  input  logic [CNTW-1:0]    trig,
  input  logic [CNTW-1:0]    acc_pretrig,
  input  logic [CNTW-1:0]    acc_trig,
  input  logic [1:0]         trig_mode,
  input  logic [DTW-1:0]     coll_dead,
  input  logic [DTW-1:0]     acc_dead,
  output logic               coll_v,
  output logic               acc_v,
  output logic [CNTW-1:0]    coll_q,
  output logic [CNTW-1:0]    acc_q
);

  localparam logic [CNTW-1:0] QOFS_C = CNTW'(QOFS);

  logic            kill_coll_s, kill_acc_s, veto_coll_s;
  logic            coll_rv_s, acc_rv_s;
  logic [CNTW-1:0] coll_sum_s, acc_sum_s;
  logic            coll_v_q, coll_v_d, acc_v_q, acc_v_d;
  logic [CNTW-1:0] coll_q_q, coll_q_d, acc_q_q, acc_q_d;

  assign kill_coll_s = (trig_mode == TM_KILL_COLL);
  assign kill_acc_s  = (trig_mode == TM_KILL_ACC);
  // Veto acts combinationally, so a mode change affects it in the same cycle.
  assign veto_coll_s = (trig_mode == TM_ACC_VETO) && acc_rv_s;

  patterner_chan #(
    .NLY(NLY), .LYW(LYW), .BXW(BXW), .CNTW(CNTW), .DTW(DTW)
  ) u_coll (
    .clk         (clk),
    .rst_n       (rst_n),
    .ly_i        (ly),
    .mask_i      (coll_mask),
    .drifttime_i (drifttime),
    .pretrig_i   (pretrig),
    .trig_i      (trig),
    .dead_i      (coll_dead),
    .kill_i      (kill_coll_s),
    .veto_i      (veto_coll_s),
    .rv_o        (coll_rv_s),
    .sum_o       (coll_sum_s)
  );

  patterner_chan #(
    .NLY(NLY), .LYW(LYW), .BXW(BXW), .CNTW(CNTW), .DTW(DTW)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .ly_i        (ly),
    .mask_i      (acc_mask),
    .drifttime_i (drifttime),
    .pretrig_i   (acc_pretrig),
    .trig_i      (acc_trig),
    .dead_i      (acc_dead),
    .kill_i      (kill_acc_s),
    .veto_i      (1'b0),
    .rv_o        (acc_rv_s),
    .sum_o       (acc_sum_s)
  );

  // Quality is the offset-corrected layer count, forced to 0 without a trigger.
  always_comb begin
    coll_v_d = coll_rv_s;
    acc_v_d  = acc_rv_s;
    coll_q_d = '0;
    acc_q_d  = '0;
    if (coll_rv_s && (coll_sum_s >= QOFS_C)) begin
      coll_q_d = coll_sum_s - QOFS_C;
    end else begin
      coll_q_d = '0;
    end
    if (acc_rv_s && (acc_sum_s >= QOFS_C)) begin
      acc_q_d = acc_sum_s - QOFS_C;
    end else begin
      acc_q_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_v_q <= 1'b0;
      acc_v_q  <= 1'b0;
      coll_q_q <= '0;
      acc_q_q  <= '0;
    end else begin
      coll_v_q <= coll_v_d;
      acc_v_q  <= acc_v_d;
      coll_q_q <= coll_q_d;
      acc_q_q  <= acc_q_d;
    end
  end

  assign coll_v = coll_v_q;
  assign acc_v  = acc_v_q;
  assign coll_q = coll_q_q;
  assign acc_q  = acc_q_q;

endmodule
